// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered flags/count and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered pop data.
module sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter int unsigned AF_LEVEL   = DEPTH - 1,
   parameter int unsigned AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  winc,
   input  logic [WIDTH-1:0]      w_data,
   input  logic                  rinc,
   output logic [WIDTH-1:0]      r_data,
   output logic                  r_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [ADDR_WIDTH:0] r_wptr;
   logic [ADDR_WIDTH:0] r_rptr;
   logic [ADDR_WIDTH:0] r_count;
   logic                r_full;
   logic                r_empty;
   logic                r_afull;
   logic                r_aempty;
   logic                r_ovf;
   logic                r_udf;

   logic                w_wr_en;
   logic                w_rd_en;
   logic [ADDR_WIDTH:0] w_wptr_nxt;
   logic [ADDR_WIDTH:0] w_rptr_nxt;
   logic [ADDR_WIDTH:0] w_count_nxt;
   logic                w_full_nxt;
   logic                w_empty_nxt;
   logic                w_afull_nxt;
   logic                w_aempty_nxt;

   assign w_wr_en = winc && !r_full;
   assign w_rd_en = rinc && !r_empty;

   // Flags come from the post-edge pointers so they can be registered glitch-free.
   always_comb begin
      w_wptr_nxt   = w_wr_en ? r_wptr + 1'b1 : r_wptr;
      w_rptr_nxt   = w_rd_en ? r_rptr + 1'b1 : r_rptr;
      w_count_nxt  = w_wptr_nxt - w_rptr_nxt;
      w_full_nxt   = (w_wptr_nxt[ADDR_WIDTH] != w_rptr_nxt[ADDR_WIDTH]) &&
                     (w_wptr_nxt[ADDR_WIDTH-1:0] == w_rptr_nxt[ADDR_WIDTH-1:0]);
      w_empty_nxt  = (w_wptr_nxt == w_rptr_nxt);
      w_afull_nxt  = 32'(w_count_nxt) >= AF_LEVEL;
      w_aempty_nxt = 32'(w_count_nxt) <= AE_LEVEL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         r_wptr   <= w_wptr_nxt;
         r_rptr   <= w_rptr_nxt;
         r_count  <= w_count_nxt;
         r_full   <= w_full_nxt;
         r_empty  <= w_empty_nxt;
         r_afull  <= w_afull_nxt;
         r_aempty <= w_aempty_nxt;
         r_ovf    <= winc && r_full;
         r_udf    <= rinc && r_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wptr[ADDR_WIDTH-1:0]] <= w_data;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is shown only while non-empty so reset forces r_data to zero.
   assign r_data  = r_empty ? '0 : r_mem[r_rptr[ADDR_WIDTH-1:0]];
   assign r_valid = !r_empty;
`else
   logic [WIDTH-1:0] r_rdata;
   logic             r_rvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         if (w_rd_en) begin
            r_rdata <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
         end
         r_rvalid <= w_rd_en;
      end
   end

   assign r_data  = r_rdata;
   assign r_valid = r_rvalid;
`endif

   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo (standard mode) against a queue model.
module tb_sync_fifo;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 3;

   logic             clk;
   logic             rst_n;
   logic             winc;
   logic [WIDTH-1:0] w_data;
   logic             rinc;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [AW:0]      count;
   logic             overflow;
   logic             underflow;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .winc         (winc),
      .w_data       (w_data),
      .rinc         (rinc),
      .r_data       (r_data),
      .r_valid      (r_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned      n_vec;
   int unsigned      n_err;
   logic [WIDTH-1:0] q_model [$];
   logic [WIDTH-1:0] exp_rdata;
   logic             exp_rvalid;
   logic             exp_ovf;
   logic             exp_udf;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int unsigned sz;
      sz = q_model.size();
      check_eq({tag, ".count"},  32'(count), sz);
      check_eq({tag, ".full"},   32'(full),  32'(sz == DEPTH));
      check_eq({tag, ".empty"},  32'(empty), 32'(sz == 0));
      check_eq({tag, ".afull"},  32'(almost_full),  32'(sz >= DEPTH - 1));
      check_eq({tag, ".aempty"}, 32'(almost_empty), 32'(sz <= 1));
      check_eq({tag, ".ovf"},    32'(overflow),  32'(exp_ovf));
      check_eq({tag, ".udf"},    32'(underflow), 32'(exp_udf));
      check_eq({tag, ".rvalid"}, 32'(r_valid),   32'(exp_rvalid));
      check_eq({tag, ".rdata"},  32'(r_data),    32'(exp_rdata));
   endtask

   // One clock: drive, let the edge happen, update the model from pre-edge occupancy, compare.
   task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
      bit was_full;
      bit was_empty;
      winc   = w;
      rinc   = r;
      w_data = d;
      @(posedge clk);
      was_full   = (q_model.size() == DEPTH);
      was_empty  = (q_model.size() == 0);
      exp_ovf    = w && was_full;
      exp_udf    = r && was_empty;
      exp_rvalid = 1'b0;
      if (r && !was_empty) begin
         exp_rdata  = q_model.pop_front();
         exp_rvalid = 1'b1;
      end
      if (w && !was_full) q_model.push_back(d);
      #1;
      winc = 1'b0;
      rinc = 1'b0;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      q_model.delete();
      exp_rdata  = '0;
      exp_rvalid = 1'b0;
      exp_ovf    = 1'b0;
      exp_udf    = 1'b0;
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      winc   = 1'b0;
      rinc   = 1'b0;
      w_data = '0;
      rst_n  = 1'b1;
      do_reset("rst0");
      step(1'b0, 1'b0, 8'h00, "idle");

      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), "fill");
      step(1'b1, 1'b0, 8'hFF, "ovf");
      step(1'b0, 1'b0, 8'h00, "ovf_end");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "drain");
      step(1'b0, 1'b1, 8'h00, "udf");
      step(1'b0, 1'b0, 8'h00, "udf_end");

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), "pre_wrap");
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom), "wrap");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "to_full");
      step(1'b1, 1'b1, 8'h5A, "full_rw");
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, "to_empty");
      step(1'b1, 1'b1, 8'hC3, "empty_rw");
      step(1'b0, 1'b1, 8'h00, "pop_c3");

      for (int i = 0; i < 400; i++) begin
         int unsigned wp;
         wp = (i < 200) ? 70 : 30;
         step(8'($urandom_range(0, 99)) < wp, 8'($urandom_range(0, 99)) < (100 - wp),
              8'($urandom), "rand");
      end

      step(1'b1, 1'b0, 8'h11, "pre_rst");
      step(1'b1, 1'b1, 8'h22, "pre_rst");
      do_reset("rst_mid");
      step(1'b1, 1'b0, 8'h77, "post_rst_wr");
      step(1'b0, 1'b1, 8'h00, "post_rst_rd");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal values 1 or more.
REQ-002 Parameter DEPTH, default 8: number of storage words; SHALL be a power of two and at least 2.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH): storage address width.
REQ-004 Parameter AF_LEVEL, default DEPTH-1: occupancy at or above which almost_full is asserted.
REQ-005 Parameter AE_LEVEL, default 1: occupancy at or below which almost_empty is asserted.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port winc, input, 1 bit: write request.
REQ-009 Port w_data, input, WIDTH bits: write data.
REQ-010 Port rinc, input, 1 bit: read request (pop).
REQ-011 Port r_data, output, WIDTH bits: read data.
REQ-012 Port r_valid, output, 1 bit: r_data holds a valid popped or head word.
REQ-013 Port full / empty, output, 1 bit each: occupancy equals DEPTH / occupancy equals 0.
REQ-014 Port almost_full / almost_empty, output, 1 bit each: occupancy >= AF_LEVEL / occupancy <= AE_LEVEL.
REQ-015 Port count, output, ADDR_WIDTH+1 bits: current occupancy, range 0..DEPTH.
REQ-016 Port overflow / underflow, output, 1 bit each: rejected write / rejected read indication.

Function
REQ-017 Write accepted when winc && !full at the clock edge; w_data stored at the write pointer, write pointer increments.
REQ-018 Read accepted when rinc && !empty at the clock edge; read pointer increments.
REQ-019 Pointers are ADDR_WIDTH+1 bits and wrap from DEPTH*2-1 to 0; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-020 full, empty, count, almost_full and almost_empty are registered, reflect state after the edge, and never glitch between edges.
REQ-021 Simultaneous accepted read and write leave count unchanged.
REQ-022 When full, winc with rinc: only the read is accepted; the write is dropped, overflow pulses and count becomes DEPTH-1.
REQ-023 When empty, rinc with winc: only the write is accepted; the read is dropped, underflow pulses and count becomes 1.
REQ-024 overflow is a one-cycle pulse, the cycle after the edge where winc && full; underflow is the same for rinc && empty.
REQ-025 Dropped writes do not modify storage or pointers; dropped reads do not modify pointers or r_data.
REQ-026 Standard mode (macro absent): r_data is registered and loaded with the popped word; valid one cycle after the accepted read edge, with r_valid high for that cycle only; r_data holds its value otherwise.

Reset
REQ-027 rst_n low asynchronously clears the pointers, count, r_data, r_valid, overflow and underflow to 0, sets empty and almost_empty to 1, and clears full and almost_full to 0.
REQ-028 Storage array contents are not reset; writes and reads in progress when rst_n falls are discarded.
REQ-029 The first accepted write is permitted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
REQ-031 With SYNC_FIFO_FWFT_EN defined, r_data continuously presents the head word and r_valid = !empty.
REQ-032 With SYNC_FIFO_FWFT_EN defined, a word written to an empty FIFO appears on r_data one cycle after the write edge; rinc consumes the head word.
REQ-033 Without SYNC_FIFO_FWFT_EN, the REQ-026 behaviour applies; all flag, count and reset behaviour is identical in both modes.

Verification (WIDTH=8, DEPTH=8, defaults)
REQ-034 Reset, then idle: empty=1, almost_empty=1, full=0, count=0, r_data=0x00, r_valid=0.
REQ-035 Write 0x01..0x08 on consecutive cycles:
- after the 7th write, almost_full=1;
- after the 8th write, full=1 and count=8;
- a 9th write of 0xFF is dropped, overflow pulses for 1 cycle, and count stays 8.
REQ-036 Standard mode, then pop 8 times: r_data = 0x01..0x08 in order, one cycle after each rinc; empty=1 after the last pop; a 9th rinc gives underflow for 1 cycle and r_data stays 0x08.
REQ-037 Wrap-around: 20 cycles of simultaneous winc/rinc at count=3; count stays 3, and the data order is preserved across pointer wrap.
REQ-038 Full with winc+rinc at once: read accepted, write dropped, overflow=1, count=7; empty with winc+rinc at once: write accepted, underflow=1, count=1.
REQ-039 FWFT build: write 0xA5 to an empty FIFO; the next cycle gives r_data=0xA5 and r_valid=1; rinc pops it, then r_valid=0 and empty=1. Assert rst_n low mid-stream and all outputs reach their reset values without a clock edge.
